// File: rtl/rotary_encoder_decoder.sv
// rtl/rotary_encoder_decoder.sv - rotary encoder front end: sync, debounce, quadrature decode, position, button
// Clean A/B/BTN levels feed a detent FSM that emits one-cycle left/right pulses.
module rotary_encoder_decoder #(
    parameter int TICK_DIV    = 25000,
    parameter int DEB_SAMPLES = 3,
    parameter int POS_W       = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enc_a,
    input  logic                    enc_b,
    input  logic                    enc_btn,
    output logic                    left,
    output logic                    right,
    output logic                    btn_press,
    output logic                    btn_level,
    output logic signed [POS_W-1:0] position
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic signed [POS_W-1:0] POS_MAX = {1'b0, {(POS_W-1){1'b1}}};
    localparam logic signed [POS_W-1:0] POS_MIN = {1'b1, {(POS_W-1){1'b0}}};
    // Bit order {btn, b, a}: encoder pins idle high, button idles low.
    localparam logic [2:0] PIN_IDLE = 3'b011;

    typedef enum logic [2:0] {
        IDLE,
        CW1,
        CW2,
        CW3,
        CCW1,
        CCW2,
        CCW3,
        RESYNC
    } state_t;

    logic [CNT_W-1:0] tick_cnt;
    logic             tick;
    logic [2:0]       pins;
    logic [2:0]       sync1;
    logic [2:0]       sync2;
    logic [2:0]       clean;
    logic [1:0]       ab;
    logic [1:0]       ab_prev;
    logic             btn_prev;
    state_t           state;

    assign pins      = {enc_btn, enc_b, enc_a};
    assign tick      = (tick_cnt == CNT_W'(TICK_DIV - 1));
    assign ab        = {clean[0], clean[1]};
    assign btn_level = clean[2];

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + CNT_W'(1);
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_pin
        logic [DEB_SAMPLES-1:0] hist;
        logic [DEB_SAMPLES-1:0] hist_nxt;

        assign hist_nxt = {hist[DEB_SAMPLES-2:0], sync2[i]};

        always_ff @(posedge clk) begin
            if (rst) begin
                sync1[i] <= PIN_IDLE[i];
                sync2[i] <= PIN_IDLE[i];
                hist     <= {DEB_SAMPLES{PIN_IDLE[i]}};
                clean[i] <= PIN_IDLE[i];
            end else begin
                sync1[i] <= pins[i];
                sync2[i] <= sync1[i];
                if (tick) begin
                    hist <= hist_nxt;
                    // Clean level moves only once the whole history agrees.
                    if (hist_nxt == {DEB_SAMPLES{1'b1}}) begin
                        clean[i] <= 1'b1;
                    end else if (hist_nxt == {DEB_SAMPLES{1'b0}}) begin
                        clean[i] <= 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ab_prev   <= 2'b11;
            btn_prev  <= 1'b0;
            left      <= 1'b0;
            right     <= 1'b0;
            btn_press <= 1'b0;
            position  <= '0;
        end else begin
            left      <= 1'b0;
            right     <= 1'b0;
            btn_press <= clean[2] & ~btn_prev;
            btn_prev  <= clean[2];
            ab_prev   <= ab;
            if (ab != ab_prev) begin
                // RESYNC exits on any update landing on the detent, even a double change.
                if (state == RESYNC) begin
                    if (ab == 2'b11) begin
                        state <= IDLE;
                    end
                end else if (ab == ~ab_prev) begin
                    state <= RESYNC;
                end else begin
                    unique case (state)
                        IDLE: begin
                            if (ab == 2'b01) begin
                                state <= CW1;
                            end else if (ab == 2'b10) begin
                                state <= CCW1;
                            end
                        end
                        CW1: begin
                            if (ab == 2'b00) begin
                                state <= CW2;
                            end else if (ab == 2'b11) begin
                                state <= IDLE;
                            end
                        end
                        CW2: begin
                            if (ab == 2'b10) begin
                                state <= CW3;
                            end else if (ab == 2'b01) begin
                                state <= CW1;
                            end
                        end
                        CW3: begin
                            if (ab == 2'b11) begin
                                state <= IDLE;
                                right <= 1'b1;
                                if (position != POS_MAX) begin
                                    position <= position + POS_W'(1);
                                end
                            end else if (ab == 2'b00) begin
                                state <= CW2;
                            end
                        end
                        CCW1: begin
                            if (ab == 2'b00) begin
                                state <= CCW2;
                            end else if (ab == 2'b11) begin
                                state <= IDLE;
                            end
                        end
                        CCW2: begin
                            if (ab == 2'b01) begin
                                state <= CCW3;
                            end else if (ab == 2'b10) begin
                                state <= CCW1;
                            end
                        end
                        CCW3: begin
                            if (ab == 2'b11) begin
                                state <= IDLE;
                                left  <= 1'b1;
                                if (position != POS_MIN) begin
                                    position <= position - POS_W'(1);
                                end
                            end else if (ab == 2'b00) begin
                                state <= CCW2;
                            end
                        end
                        default: state <= RESYNC;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_rotary_encoder_decoder.sv
// tb/tb_rotary_encoder_decoder.sv - randomized self-checking bench for rotary_encoder_decoder
module tb_rotary_encoder_decoder;

    localparam int TICK_DIV    = 4;
    localparam int DEB_SAMPLES = 3;
    localparam int POS_W       = 4;
    localparam int HOLD        = 20;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    enc_a = 1'b1;
    logic                    enc_b = 1'b1;
    logic                    enc_btn = 1'b0;
    logic                    left;
    logic                    right;
    logic                    btn_press;
    logic                    btn_level;
    logic signed [POS_W-1:0] position;

    int checks = 0;
    int errors = 0;

    rotary_encoder_decoder #(
        .TICK_DIV(TICK_DIV),
        .DEB_SAMPLES(DEB_SAMPLES),
        .POS_W(POS_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enc_a(enc_a),
        .enc_b(enc_b),
        .enc_btn(enc_btn),
        .left(left),
        .right(right),
        .btn_press(btn_press),
        .btn_level(btn_level),
        .position(position)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Monitor of output pulses, sampled on the falling edge.
    int n_right = 0, n_left = 0, n_press = 0, n_overlap = 0, n_wide = 0;
    int n_tick = 0, n_tick_bad = 0, last_tick = -1, last_press = -1, n_level = 0;
    int n_clean_a_low = 0;
    logic prev_r = 1'b0, prev_l = 1'b0, prev_p = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            last_tick = -1;
        end else begin
            if (right) n_right++;
            if (left) n_left++;
            if (left && right) n_overlap++;
            if ((right && prev_r) || (left && prev_l) || (btn_press && prev_p)) n_wide++;
            if (btn_press) begin
                n_press++;
                last_press = cyc;
            end
            if (btn_level) n_level++;
            if (!dut.clean[0]) n_clean_a_low++;
            if (dut.tick) begin
                if (last_tick >= 0 && cyc - last_tick != TICK_DIV) n_tick_bad++;
                last_tick = cyc;
                n_tick++;
            end
        end
        prev_r = right;
        prev_l = left;
        prev_p = btn_press;
    end

    // Reference model: detent decoding as a path of visited ab values since the last 11.
    logic [1:0] m_ab;
    logic [1:0] m_path[$];
    bit         m_bad;
    int         m_pos, m_right, m_left;

    function automatic void model_reset();
        m_ab = 2'b11;
        m_path.delete();
        m_bad = 1'b0;
        m_pos = 0;
    endfunction

    function automatic void model_step(logic [1:0] nab);
        int max_p = (1 << (POS_W - 1)) - 1;
        int min_p = -(1 << (POS_W - 1));
        if (nab == m_ab) return;
        if (m_bad) begin
            if (nab == 2'b11) begin
                m_bad = 1'b0;
                m_path.delete();
            end
        end else if (nab == ~m_ab) begin
            m_bad = 1'b1;
            m_path.delete();
        end else if (nab == 2'b11) begin
            if (m_path.size() == 3 && m_path[0] == 2'b01 && m_path[1] == 2'b00 && m_path[2] == 2'b10) begin
                m_right++;
                if (m_pos < max_p) m_pos++;
            end else if (m_path.size() == 3 && m_path[0] == 2'b10 && m_path[1] == 2'b00 && m_path[2] == 2'b01) begin
                m_left++;
                if (m_pos > min_p) m_pos--;
            end
            m_path.delete();
        end else if (m_path.size() >= 2 && m_path[m_path.size()-2] == nab) begin
            void'(m_path.pop_back());
        end else begin
            m_path.push_back(nab);
        end
        m_ab = nab;
    endfunction

    task automatic set_ab(input logic [1:0] ab, input int hold);
        @(posedge clk);
        #1;
        enc_a = ab[1];
        enc_b = ab[0];
        model_step(ab);
        repeat (hold) @(posedge clk);
    endtask

    task automatic cw_detent();
        set_ab(2'b01, HOLD);
        set_ab(2'b00, HOLD);
        set_ab(2'b10, HOLD);
        set_ab(2'b11, HOLD);
    endtask

    task automatic ccw_detent();
        set_ab(2'b10, HOLD);
        set_ab(2'b00, HOLD);
        set_ab(2'b01, HOLD);
        set_ab(2'b11, HOLD);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        int t0;
        enc_a = 1'b1;
        enc_b = 1'b1;
        enc_btn = 1'b0;
        do_reset();
        @(negedge clk);
        checks++;
        if ({left, right, btn_press, btn_level} !== 4'b0000 || position !== 4'sd0) begin
            errors++;
            $display("FAIL reset_outputs: got l=%b r=%b p=%b lvl=%b pos=%0d, need all 0", left, right, btn_press, btn_level, position);
        end
        t0 = n_tick;
        repeat (40) @(posedge clk);
        checks++;
        if (n_tick - t0 !== 10 || n_tick_bad !== 0) begin
            errors++;
            $display("FAIL tick_period: got %0d ticks, %0d bad gaps, need 10 ticks, 0 bad", n_tick - t0, n_tick_bad);
        end
    endtask

    task automatic test_cw();
        int r0, l0;
        do_reset();
        r0 = n_right; l0 = n_left;
        cw_detent();
        @(negedge clk);
        checks++;
        if (n_right - r0 !== 1 || n_left - l0 !== 0 || int'(position) !== 1 || n_wide !== 0) begin
            errors++;
            $display("FAIL cw_detent: got right=%0d left=%0d pos=%0d wide=%0d, need 1 0 1 0", n_right - r0, n_left - l0, position, n_wide);
        end
    endtask

    task automatic test_ccw();
        int r0, l0;
        do_reset();
        r0 = n_right; l0 = n_left;
        repeat (3) ccw_detent();
        @(negedge clk);
        checks++;
        if (n_left - l0 !== 3 || n_right - r0 !== 0 || int'(position) !== -3) begin
            errors++;
            $display("FAIL ccw_detent: got left=%0d right=%0d pos=%0d, need 3 0 -3", n_left - l0, n_right - r0, position);
        end
    endtask

    task automatic test_saturate();
        int r0, l0;
        do_reset();
        r0 = n_right;
        repeat (9) cw_detent();
        @(negedge clk);
        checks++;
        if (n_right - r0 !== 9 || int'(position) !== 7) begin
            errors++;
            $display("FAIL sat_high: got right=%0d pos=%0d, need 9 7", n_right - r0, position);
        end
        do_reset();
        l0 = n_left;
        repeat (10) ccw_detent();
        @(negedge clk);
        checks++;
        if (n_left - l0 !== 10 || int'(position) !== -8) begin
            errors++;
            $display("FAIL sat_low: got left=%0d pos=%0d, need 10 -8", n_left - l0, position);
        end
    endtask

    task automatic test_glitch();
        int r0, l0, lo0;
        do_reset();
        repeat (HOLD) @(posedge clk);
        r0 = n_right; l0 = n_left; lo0 = n_clean_a_low;
        @(posedge clk);
        #1 enc_a = 1'b0;
        repeat (6) @(posedge clk);
        #1 enc_a = 1'b1;
        repeat (HOLD) @(posedge clk);
        @(negedge clk);
        checks++;
        if (n_clean_a_low - lo0 !== 0 || n_right - r0 !== 0 || n_left - l0 !== 0) begin
            errors++;
            $display("FAIL glitch: got clean_a_low=%0d right=%0d left=%0d, need 0 0 0", n_clean_a_low - lo0, n_right - r0, n_left - l0);
        end
    endtask

    task automatic test_partial();
        int r0, l0;
        do_reset();
        r0 = n_right; l0 = n_left;
        set_ab(2'b01, HOLD);
        set_ab(2'b11, HOLD);
        @(negedge clk);
        checks++;
        if (n_right - r0 !== 0 || n_left - l0 !== 0 || int'(position) !== 0) begin
            errors++;
            $display("FAIL partial_cw: got right=%0d left=%0d pos=%0d, need 0 0 0", n_right - r0, n_left - l0, position);
        end
        cw_detent();
        @(negedge clk);
        checks++;
        if (n_right - r0 !== 1 || int'(position) !== 1) begin
            errors++;
            $display("FAIL after_partial: got right=%0d pos=%0d, need 1 1", n_right - r0, position);
        end
    endtask

    task automatic test_reset_mid();
        int r0, l0;
        do_reset();
        set_ab(2'b01, HOLD);
        set_ab(2'b00, HOLD);
        do_reset();
        model_step(2'b00);
        repeat (HOLD) @(posedge clk);
        r0 = n_right; l0 = n_left;
        set_ab(2'b11, HOLD);
        @(negedge clk);
        checks++;
        if (n_right - r0 !== 0 || n_left - l0 !== 0 || int'(position) !== 0) begin
            errors++;
            $display("FAIL reset_mid: got right=%0d left=%0d pos=%0d, need 0 0 0", n_right - r0, n_left - l0, position);
        end
        cw_detent();
        @(negedge clk);
        checks++;
        if (n_right - r0 !== 1 || n_left - l0 !== 0 || int'(position) !== 1) begin
            errors++;
            $display("FAIL reset_mid_cw: got right=%0d left=%0d pos=%0d, need 1 0 1", n_right - r0, n_left - l0, position);
        end
    endtask

    task automatic test_button();
        int p0, lv0, t_rise, lat;
        do_reset();
        p0 = n_press; lv0 = n_level;
        @(posedge clk);
        #1 enc_btn = 1'b1;
        t_rise = cyc;
        repeat (40) @(posedge clk);
        #1 enc_btn = 1'b0;
        lat = last_press - t_rise;
        checks++;
        if (n_press - p0 !== 1 || lat < 6 || lat > 2 + (DEB_SAMPLES + 1) * TICK_DIV + 2) begin
            errors++;
            $display("FAIL btn_press: got %0d presses latency %0d, need 1 press latency 6..20", n_press - p0, lat);
        end
        checks++;
        if (n_level - lv0 < 20) begin
            errors++;
            $display("FAIL btn_level_hold: got %0d high cycles, need >= 20", n_level - lv0);
        end
        repeat (30) @(posedge clk);
        @(negedge clk);
        checks++;
        if (btn_level !== 1'b0 || n_press - p0 !== 1 || n_wide !== 0) begin
            errors++;
            $display("FAIL btn_release: got level=%b presses=%0d wide=%0d, need 0 1 0", btn_level, n_press - p0, n_wide);
        end
    endtask

    task automatic test_random();
        int r0, l0;
        logic [1:0] nab;
        do_reset();
        r0 = n_right; l0 = n_left;
        m_right = 0; m_left = 0;
        for (int i = 0; i < 120; i++) begin
            nab = m_ab;
            if ($urandom_range(0, 9) == 0) nab = ~nab;
            else if ($urandom_range(0, 1) == 0) nab[0] = ~nab[0];
            else nab[1] = ~nab[1];
            set_ab(nab, $urandom_range(16, 24));
        end
        set_ab(2'b11, HOLD);
        @(negedge clk);
        checks++;
        if (n_right - r0 !== m_right || n_left - l0 !== m_left || int'(position) !== m_pos) begin
            errors++;
            $display("FAIL random_walk: got right=%0d left=%0d pos=%0d, need %0d %0d %0d",
                     n_right - r0, n_left - l0, position, m_right, m_left, m_pos);
        end
        checks++;
        if (n_overlap !== 0 || n_wide !== 0) begin
            errors++;
            $display("FAIL pulse_shape: got overlap=%0d wide=%0d, need 0 0", n_overlap, n_wide);
        end
    endtask

    initial begin
        model_reset();
        m_right = 0;
        m_left = 0;
        test_reset();
        test_cw();
        test_ccw();
        test_saturate();
        test_glitch();
        test_partial();
        test_reset_mid();
        test_button();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
